serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl_pkg.sv | 12 +
 rtl/serial_adder_ctrl_if.sv | 28 ++
 rtl/serial_adder_ctrl_bit_slice_fa.sv | 13 +
 rtl/serial_adder_ctrl.sv | 90 +++++++++
 tb/tb_serial_adder_ctrl.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding and default width.
package serial_adder_ctrl_pkg;

    localparam int SA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } sa_state_e;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Requester <-> serial adder handshake bundle.
// The sub port exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_adder_ctrl_if
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEF
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADD_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/serial_adder_ctrl_bit_slice_fa.sv
// Combinational 1-bit full adder, time-shared across all bit positions.
module bit_slice_fa (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder slice, LSB first, one bit per clock.
// Optional subtract mode under macro SERIAL_ADD_SUB_EN.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    sa_state_e        state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             cout_q;

    logic [WIDTH-1:0] b_ld;
    logic             c_ld;
    logic             fa_s;
    logic             fa_co;

`ifdef SERIAL_ADD_SUB_EN
    // a - b == a + ~b + 1; a final carry of 1 means no borrow
    assign b_ld = bus.sub ? ~bus.b : bus.b;
    assign c_ld = bus.sub | bus.cin;
`else
    assign b_ld = bus.b;
    assign c_ld = bus.cin;
`endif

    bit_slice_fa u_fa (
        .x  (a_sh_q[0]),
        .y  (b_sh_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        a_sh_q  <= bus.a;
                        b_sh_q  <= b_ld;
                        carry_q <= c_ld;
                        cnt_q   <= '0;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    // Result enters at the MSB so after WIDTH shifts bit 0 sits at sum[0]
                    sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
                    carry_q <= fa_co;
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        cout_q  <= fa_co;
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8); define SERIAL_ADD_SUB_EN to add subtract vectors.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    exp_t e;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result and its cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("sum", 32'(bus.sum), 32'(e.sum));
                    chk("cout", 32'(bus.cout), 32'(e.cout));
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else if (q.size() > 0 && cyc > q[0].cyc) begin
                e = q.pop_front();
                chk("missed_done", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
        bus.a   = a;
        bus.b   = b;
        bus.cin = c;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub = s;
`else
        if (s) $display("note: sub vector skipped in add-only build");
`endif
    endtask

    // Drives start for one cycle; returns the accepting edge number.
    task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                            input logic s, input logic [W-1:0] xsum, input logic xcout,
                            input bit push, output int acc);
        @(negedge clk);
        drive(a, b, c, s);
        bus.start = 1'b1;
        acc = cyc + 1;
        if (push) q.push_back('{sum: xsum, cout: xcout, cyc: acc + W});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            chk("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int acc;
        bus.start = 1'b0;
        drive('0, '0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of a run aborts without a done pulse
        do_start(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, acc);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_sum", 32'(bus.sum), 32'd0);
        chk("abort_cout", 32'(bus.cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        // Basic add, also checking busy is high for exactly 8 cycles
        do_start(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, acc);
        for (int i = 1; i <= 9; i++) begin
            if (i > 1) @(negedge clk);
            chk("busy_window", 32'(bus.busy), (i <= 8) ? 32'd1 : 32'd0);
        end
        wait_drain();

        do_start(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);
        wait_drain();
        do_start(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, acc);
        wait_drain();
        do_start(8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, acc);
        wait_drain();
        do_start(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);
        wait_drain();

        // Start during RUN is ignored
        do_start(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b1, acc);
        @(negedge clk);
        drive(8'h01, 8'h01, 1'b0, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_drain();

        // Back-to-back: start held from mid-run through the DONE cycle
        do_start(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b1, acc);
        repeat (4) @(negedge clk);
        drive(8'h10, 8'h20, 1'b0, 1'b0);
        bus.start = 1'b1;
        q.push_back('{sum: 8'h30, cout: 1'b0, cyc: acc + W + 1 + W});
        while (cyc < acc + W + 1) @(negedge clk);
        bus.start = 1'b0;
        wait_drain();

`ifdef SERIAL_ADD_SUB_EN
        do_start(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b1, acc);
        wait_drain();
        do_start(8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, acc);
        wait_drain();
        do_start(8'h05, 8'h03, 1'b1, 1'b0, 8'h09, 1'b0, 1'b1, acc);
        wait_drain();
`endif

        // Idle tail catches any stray done pulse
        repeat (12) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
